// File: rtl/parking_gate_arbiter.sv
// Two-lane parking gate arbiter: round-robin entry/exit grant, password wait, gate timeout, occupancy tracking.
// Optional PARKING_GATE_STATS_EN adds 16-bit completed-transaction counters per direction.
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        entry_req,
    input  logic        exit_req,
    input  logic        pass_ok,
    input  logic        car_passed,
    output logic        grant_entry,
    output logic        grant_exit,
    output logic        gate_open,
    output logic        lot_full,
`ifdef PARKING_GATE_STATS_EN
    output logic [3:0]  free_slots,
    output logic [15:0] entry_count,
    output logic [15:0] exit_count
`else
    output logic [3:0]  free_slots
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_ENTRY,
        GRANT_EXIT,
        OPEN,
        CLOSE
    } state_t;

    localparam logic [3:0] CAP       = 4'(CAPACITY);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic       DIR_ENTRY = 1'b1;
    localparam logic       DIR_EXIT  = 1'b0;

    state_t     state_q, state_d;
    logic [3:0] occ_q, occ_d;
    logic [7:0] wait_q, wait_d;
    logic       last_dir_q, last_dir_d;
    logic       entry_elig, exit_elig, timed_out, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            wait_q     <= '0;
            last_dir_q <= DIR_EXIT;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            wait_q     <= wait_d;
            last_dir_q <= last_dir_d;
        end
    end

    // last_dir is written on every grant, so it also names the direction of the transaction in flight.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        last_dir_d = last_dir_q;
        done       = 1'b0;
        entry_elig = entry_req && (occ_q != CAP);
        exit_elig  = exit_req && (occ_q != 4'd0);
        timed_out  = (wait_q == WAIT_LAST);
        case (state_q)
            IDLE: begin
                if (entry_elig && (!exit_elig || last_dir_q == DIR_EXIT)) begin
                    state_d    = GRANT_ENTRY;
                    last_dir_d = DIR_ENTRY;
                end else if (exit_elig) begin
                    state_d    = GRANT_EXIT;
                    last_dir_d = DIR_EXIT;
                end
            end
            GRANT_ENTRY: begin
                if (pass_ok)        state_d = OPEN;
                else if (timed_out) state_d = IDLE;
            end
            GRANT_EXIT: state_d = OPEN;
            OPEN: begin
                if (car_passed) begin
                    state_d = CLOSE;
                    done    = 1'b1;
                    if (last_dir_q == DIR_ENTRY) begin
                        if (occ_q != CAP) occ_d = occ_q + 4'd1;
                    end else begin
                        if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
                    end
                end else if (timed_out) begin
                    state_d = CLOSE;
                end
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            wait_d = '0;
        else if (state_q == GRANT_ENTRY || state_q == OPEN)
            wait_d = wait_q + 8'd1;
        else
            wait_d = '0;
    end

    always_comb begin
        grant_entry = (last_dir_q == DIR_ENTRY) &&
                      (state_q == GRANT_ENTRY || state_q == OPEN || state_q == CLOSE);
        grant_exit  = (last_dir_q == DIR_EXIT) &&
                      (state_q == GRANT_EXIT || state_q == OPEN || state_q == CLOSE);
        gate_open   = (state_q == OPEN);
        lot_full    = (occ_q == CAP);
        free_slots  = CAP - occ_q;
    end

`ifdef PARKING_GATE_STATS_EN
    logic [15:0] entry_cnt_q, entry_cnt_d, exit_cnt_q, exit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_cnt_q <= '0;
            exit_cnt_q  <= '0;
        end else begin
            entry_cnt_q <= entry_cnt_d;
            exit_cnt_q  <= exit_cnt_d;
        end
    end

    always_comb begin
        entry_cnt_d = entry_cnt_q;
        exit_cnt_d  = exit_cnt_q;
        if (done && last_dir_q == DIR_ENTRY) entry_cnt_d = entry_cnt_q + 16'd1;
        if (done && last_dir_q == DIR_EXIT)  exit_cnt_d  = exit_cnt_q + 16'd1;
    end

    assign entry_count = entry_cnt_q;
    assign exit_count  = exit_cnt_q;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter (CAPACITY=8, TIMEOUT=16): vector tables plus scoreboarded hand sequences.
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0, pass_ok = 1'b0, car_passed = 1'b0;
    logic       grant_entry, grant_exit, gate_open, lot_full;
    logic [3:0] free_slots;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned occ_m = 0;

    typedef struct {
        logic       e, x, p, c;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    parking_gate_arbiter #(.CAPACITY(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_req(entry_req), .exit_req(exit_req),
        .pass_ok(pass_ok), .car_passed(car_passed),
        .grant_entry(grant_entry), .grant_exit(grant_exit),
        .gate_open(gate_open), .lot_full(lot_full), .free_slots(free_slots)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (grant_entry && grant_exit) begin
                bad++;
                $display("FAIL grant_overlap: got both grants high, required at most one");
            end
        end
    end

    function automatic logic [7:0] o(input logic ge, gx, go, lf, input int unsigned fs);
        return {ge, gx, go, lf, 4'(fs)};
    endfunction

    function automatic logic [7:0] outs();
        return {grant_entry, grant_exit, gate_open, lot_full, free_slots};
    endfunction

    function automatic void add(input logic e, x, p, c, input logic [7:0] exp, input string name);
        vec_t v;
        v.e = e; v.x = x; v.p = p; v.c = c; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check_now(input logic [7:0] exp, input string name);
        total++;
        if (outs() !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, outs(), exp);
        end
    endtask

    task automatic step(input logic e, x, p, c, input logic [7:0] exp, input string name);
        logic [7:0] want;
        entry_req = e; exit_req = x; pass_ok = p; car_passed = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        total++;
        if (outs() !== want) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, outs(), want);
        end
        pass_ok = 1'b0; car_passed = 1'b0;
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) step(vecs[i].e, vecs[i].x, vecs[i].p, vecs[i].c, vecs[i].exp, vecs[i].name);
        vecs.delete();
        entry_req = 1'b0; exit_req = 1'b0;
    endtask

    task automatic do_entry();
        step(1, 0, 0, 0, o(1, 0, 0, 0, 8 - occ_m), "ent_grant");
        step(1, 0, 1, 0, o(1, 0, 1, 0, 8 - occ_m), "ent_open");
        occ_m++;
        step(0, 0, 0, 1, o(1, 0, 0, occ_m == 8, 8 - occ_m), "ent_close");
        step(0, 0, 0, 0, o(0, 0, 0, occ_m == 8, 8 - occ_m), "ent_idle");
    endtask

    task automatic do_exit();
        step(0, 1, 0, 0, o(0, 1, 0, occ_m == 8, 8 - occ_m), "ext_grant");
        step(0, 1, 0, 0, o(0, 1, 1, occ_m == 8, 8 - occ_m), "ext_open");
        occ_m--;
        step(0, 0, 0, 1, o(0, 1, 0, 0, 8 - occ_m), "ext_close");
        step(0, 0, 0, 0, o(0, 0, 0, 0, 8 - occ_m), "ext_idle");
    endtask

    initial begin
        #12;
        check_now(o(0, 0, 0, 0, 8), "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single entry: pass_ok 3 cycles after grant, car_passed 2 cycles later; request dropped mid-way.
        add(1, 0, 0, 0, o(1, 0, 0, 0, 8), "a_grant");
        add(1, 0, 0, 0, o(1, 0, 0, 0, 8), "a_wait1");
        add(1, 0, 0, 0, o(1, 0, 0, 0, 8), "a_wait2");
        add(1, 0, 1, 0, o(1, 0, 1, 0, 8), "a_open");
        add(0, 0, 0, 0, o(1, 0, 1, 0, 8), "a_open_hold");
        add(0, 0, 0, 1, o(1, 0, 0, 0, 7), "a_close");
        add(0, 0, 0, 0, o(0, 0, 0, 0, 7), "a_idle");
        add(0, 0, 1, 1, o(0, 0, 0, 0, 7), "a_stray_pulses");
        run_vecs();
        occ_m = 1;

        repeat (3) do_entry();
        do_exit();

        // Tie at occupancy 3 with last_dir=exit: entry first, then exit.
        add(1, 1, 0, 0, o(1, 0, 0, 0, 5), "b_tie_entry");
        add(1, 1, 1, 0, o(1, 0, 1, 0, 5), "b_entry_open");
        add(1, 1, 0, 1, o(1, 0, 0, 0, 4), "b_entry_close");
        add(1, 1, 0, 0, o(0, 0, 0, 0, 4), "b_idle");
        add(1, 1, 1, 0, o(0, 1, 0, 0, 4), "b_tie_exit");
        add(1, 1, 0, 0, o(0, 1, 1, 0, 4), "b_exit_open");
        add(1, 1, 0, 1, o(0, 1, 0, 0, 5), "b_exit_close");
        add(0, 0, 0, 0, o(0, 0, 0, 0, 5), "b_idle2");
        run_vecs();
        occ_m = 3;

        repeat (5) do_entry();
        check_now(o(0, 0, 0, 1, 0), "full_flag");

        add(1, 0, 0, 0, o(0, 0, 0, 1, 0), "c_full_no_grant1");
        add(1, 0, 0, 0, o(0, 0, 0, 1, 0), "c_full_no_grant2");
        add(1, 1, 0, 0, o(0, 1, 0, 1, 0), "c_exit_grant");
        add(0, 1, 0, 0, o(0, 1, 1, 1, 0), "c_exit_open");
        add(0, 0, 0, 1, o(0, 1, 0, 0, 1), "c_full_falls");
        add(0, 0, 0, 0, o(0, 0, 0, 0, 1), "c_idle");
        run_vecs();
        occ_m = 7;

        // Password timeout: 16 cycles in GRANT_ENTRY then back to IDLE.
        step(1, 0, 0, 0, o(1, 0, 0, 0, 1), "d_grant");
        for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, o(1, 0, 0, 0, 1), "d_wait");
        step(0, 0, 0, 0, o(0, 0, 0, 0, 1), "d_timeout_idle");
        step(0, 0, 1, 0, o(0, 0, 0, 0, 1), "d_late_pass");

        // Gate timeout: exit with no car_passed closes with no count change.
        step(0, 1, 0, 0, o(0, 1, 0, 0, 1), "e_grant");
        step(0, 0, 0, 0, o(0, 1, 1, 0, 1), "e_open");
        for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, o(0, 1, 1, 0, 1), "e_open_wait");
        step(0, 0, 0, 0, o(0, 1, 0, 0, 1), "e_timeout_close");
        step(0, 0, 0, 0, o(0, 0, 0, 0, 1), "e_idle");

        // Async reset while OPEN, then a late car_passed.
        step(1, 0, 0, 0, o(1, 0, 0, 0, 1), "f_grant");
        step(0, 0, 1, 0, o(1, 0, 1, 0, 1), "f_open");
        #2 rst_n = 1'b0;
        #1 check_now(o(0, 0, 0, 0, 8), "f_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        occ_m = 0;
        step(0, 0, 0, 1, o(0, 0, 0, 0, 8), "f_late_car");

        // Empty lot: exit request never granted.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, o(0, 0, 0, 0, 8), "g_empty_exit");
        exit_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 8, number of parking slots; the legal range SHALL be 1..15.
REQ-002 Parameter TIMEOUT, default 16, cycle limit for the password wait and for the gate-open wait; the legal range SHALL be 2..255.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port entry_req, input, 1, a car is present at the entry lane (level).
REQ-006 Port exit_req, input, 1, a car is present at the exit lane (level).
REQ-007 Port pass_ok, input, 1, one-cycle pulse from the password checker meaning a correct password was entered.
REQ-008 Port car_passed, input, 1, one-cycle pulse from the gate sensor meaning the car has cleared the gate.
REQ-009 Port grant_entry, output, 1, the entry lane owns the gate.
REQ-010 Port grant_exit, output, 1, the exit lane owns the gate.
REQ-011 Port gate_open, output, 1, drive to the barrier.
REQ-012 Port lot_full, output, 1, high when occupancy equals CAPACITY.
REQ-013 Port free_slots, output, 4, CAPACITY minus occupancy.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT_ENTRY, GRANT_EXIT, OPEN and CLOSE; every output SHALL be registered or decoded from state registers only.
REQ-015 Eligibility SHALL be defined as: entry eligible = entry_req && !lot_full; exit eligible = exit_req && occupancy>0.
REQ-016 In IDLE with exactly one lane eligible, the FSM SHALL go to that lane's GRANT state on the next edge.
REQ-017 In IDLE with both lanes eligible, the FSM SHALL grant the lane other than last_dir (round-robin), and last_dir SHALL be updated on every grant.
REQ-018 grant_entry SHALL be high in GRANT_ENTRY, OPEN and CLOSE for an entry transaction; grant_exit SHALL follow the same rule for an exit transaction; the two grants SHALL never be high together.
REQ-019 In GRANT_ENTRY, pass_ok SHALL move the FSM to OPEN; if TIMEOUT cycles elapse without pass_ok, the FSM SHALL go to IDLE with no count change.
REQ-020 GRANT_EXIT SHALL last exactly 1 cycle and then go to OPEN, with no password required.
REQ-021 gate_open SHALL be high exactly while in OPEN.
REQ-022 In OPEN, car_passed SHALL move the FSM to CLOSE, incrementing occupancy for an entry transaction or decrementing it for an exit transaction in the same edge.
REQ-023 In OPEN, if TIMEOUT cycles elapse without car_passed, the FSM SHALL go to CLOSE with no count change.
REQ-024 CLOSE SHALL last exactly 1 cycle and then go to IDLE, so a new grant cannot occur earlier than 2 cycles after the gate closes.
REQ-025 The wait counter SHALL clear on every state change and count only in GRANT_ENTRY and OPEN.
REQ-026 Occupancy SHALL saturate at 0 and at CAPACITY; it SHALL never wrap.
REQ-027 pass_ok and car_passed SHALL be ignored in every state other than the one that consumes them.
REQ-028 A request that drops while its lane is granted SHALL NOT abort the transaction; only a timeout SHALL end it.

Reset
REQ-029 Asserting rst_n low SHALL immediately force the following, including mid-transaction: state=IDLE, occupancy=0, wait counter=0, last_dir=exit (so entry wins the first tie), gate_open=0, grants=0, lot_full=0, free_slots=CAPACITY.
REQ-030 Reset release SHALL take effect on the first rising clk edge after rst_n goes high.

Configuration
REQ-031 When the macro PARKING_GATE_STATS_EN is defined, the block SHALL add output port entry_count (16 bits) and output port exit_count (16 bits); each SHALL increment on a completed transaction of its direction, wrap at 16'hFFFF to 0, and clear on reset.
REQ-032 When PARKING_GATE_STATS_EN is undefined, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then entry_req=1, pass_ok pulse 3 cycles after the grant, car_passed 2 cycles later -> gate_open high for those 2 cycles, then free_slots=7 and grant_entry low 2 cycles after car_passed.
REQ-034 Occupancy=3, entry_req and exit_req asserted in the same cycle with last_dir=exit -> entry served first, then exit; grants never overlap.
REQ-035 Fill to CAPACITY=8 -> lot_full=1; entry_req alone -> no grant; exit_req -> exit served, lot_full falls in the car_passed edge.
REQ-036 GRANT_ENTRY with no pass_ok for 16 cycles -> return to IDLE, gate_open never high, free_slots unchanged.
REQ-037 rst_n pulsed low during OPEN -> gate_open=0 and free_slots=CAPACITY asynchronously; a late car_passed after release has no effect.
REQ-038 Occupancy=0 with exit_req=1 -> no grant; occupancy never underflows.
